dmem_ctrl: RTL

- Parametrised single-port data memory for the pipelined CPU, replacing the fixed 32-bit, 51-word array.
- Adds a request/ready handshake, byte-lane write strobes, a registered read with configurable latency, and an address fault flag.
- Adds a post-reset clearing sequencer that zero-fills every word before the first access.
- Sits between the MEM stage and the data RAM. The MEM stage stalls on ready=0 and consumes rdata on rvalid.

---
 rtl/dmem_ctrl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: parametrised single-port data memory for the pipelined CPU MEM stage.
//
// After reset a clearing sequencer zero-fills every word (ready=0, init_done=0), then the
// controller accepts one access per cycle. Writes commit at the accepting edge under byte-lane
// strobes; reads return after RD_LAT (1 or 2) cycles. Misaligned or out-of-range accesses raise
// a one-cycle fault at read latency and never touch the array.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   req, we, be        request, write select, byte-lane write enables
//   addr, wdata        byte address, write data
//   ready              request accepted this cycle when req & ready
//   rvalid, rdata      read data pulse; rdata holds between pulses
//   fault              access (or parity) error pulse, aligned with rvalid timing
//   par_err            parity error pulse (only with DMEM_PARITY_EN)
//   init_done          zero-fill complete
//
// Build option: define DMEM_PARITY_EN to add per-byte even parity and the par_err port.
module dmem_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  ready,
  output logic                  rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  fault,
`ifdef DMEM_PARITY_EN
  output logic                  par_err,
`endif
  output logic                  init_done
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(NB - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Reset is released into the sequencer synchronously; assertion stays asynchronous.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       run_en;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign run_en     = rst_sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  // Clearing sequencer
  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (run_en && (state_q == ST_INIT)) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == IDX_W'(DEPTH - 1)) begin
        state_d = ST_RUN;
        ptr_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign ready     = (state_q == ST_RUN);
  assign init_done = (state_q == ST_RUN);

  // Access decode; the index is compared at full width so large addresses never alias.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] idx_full;
  logic [IDX_W-1:0]  idx;
  logic              acc, bad;
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    idx_full = addr >> OFF_W;
    idx      = idx_full[IDX_W-1:0];
    bad      = ((addr & OFF_MASK) != '0) || (idx_full >= DEPTH_A);
    acc      = req & ready;
    rd_word  = mem_q[idx];
  end

  // Single write port shared by the sequencer and accepted writes.
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [NB-1:0]     mem_be;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = idx;
    mem_be    = be;
    mem_wdata = wdata;
    if (state_q == ST_INIT) begin
      mem_we    = run_en;
      mem_idx   = ptr_q;
      mem_be    = '1;
      mem_wdata = '0;
    end else if (acc && we && !bad) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) mem_q[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // First read stage
  logic              s1_rv_q, s1_rv_d, s1_flt_q, s1_flt_d, s1_perr_q, s1_perr_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;

`ifdef DMEM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] wpar, rd_mis;

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      wpar[i]   = ^mem_wdata[8*i +: 8];
      rd_mis[i] = (^rd_word[8*i +: 8]) ^ par_q[idx][i];
    end
    s1_perr_d = acc & ~we & ~bad & (|rd_mis);
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) par_q[mem_idx][i] <= wpar[i];
      end
    end
  end
`else
  assign s1_perr_d = 1'b0;
`endif

  always_comb begin
    s1_rv_d   = acc & ~we;
    s1_flt_d  = acc & bad;
    s1_data_d = s1_data_q;
    if (s1_rv_d) s1_data_d = bad ? '0 : rd_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_rv_q   <= 1'b0;
      s1_flt_q  <= 1'b0;
      s1_perr_q <= 1'b0;
      s1_data_q <= '0;
    end else begin
      s1_rv_q   <= s1_rv_d;
      s1_flt_q  <= s1_flt_d;
      s1_perr_q <= s1_perr_d;
      s1_data_q <= s1_data_d;
    end
  end

  logic              out_rv, out_flt, out_perr;
  logic [DATA_W-1:0] out_data;

  if (RD_LAT == 2) begin : g_lat2
    logic              rv2_q, rv2_d, flt2_q, flt2_d, perr2_q, perr2_d;
    logic [DATA_W-1:0] data2_q, data2_d;

    always_comb begin
      rv2_d   = s1_rv_q;
      flt2_d  = s1_flt_q;
      perr2_d = s1_perr_q;
      data2_d = s1_rv_q ? s1_data_q : data2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rv2_q   <= 1'b0;
        flt2_q  <= 1'b0;
        perr2_q <= 1'b0;
        data2_q <= '0;
      end else begin
        rv2_q   <= rv2_d;
        flt2_q  <= flt2_d;
        perr2_q <= perr2_d;
        data2_q <= data2_d;
      end
    end

    assign out_rv   = rv2_q;
    assign out_flt  = flt2_q;
    assign out_perr = perr2_q;
    assign out_data = data2_q;
  end else begin : g_lat1
    assign out_rv   = s1_rv_q;
    assign out_flt  = s1_flt_q;
    assign out_perr = s1_perr_q;
    assign out_data = s1_data_q;
  end

  assign rvalid = out_rv;
  assign rdata  = out_data;
  assign fault  = out_flt | out_perr;
`ifdef DMEM_PARITY_EN
  assign par_err = out_perr;
`endif

endmodule
